// File: rtl/cam_window_decimator.sv
// Camera pixel conditioner: crops each sensor frame to a programmable window,
// decimates by 2^decim_log2 in x and y, and regenerates vsync/href/p_data.
module cam_window_decimator #(
  parameter int unsigned BYTES_PER_PIX = 2,
  parameter int unsigned COL_W         = 11,
  parameter int unsigned ROW_W         = 10
) (
  input  logic             p_clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic [COL_W-1:0] x_start,
  input  logic [COL_W-1:0] x_len,
  input  logic [ROW_W-1:0] y_start,
  input  logic [ROW_W-1:0] y_len,
  input  logic [1:0]       decim_log2,
  input  logic             vsync_in,
  input  logic             href_in,
  input  logic [7:0]       p_data_in,
  output logic             vsync_out,
  output logic             href_out,
  output logic [7:0]       p_data_out,
  output logic             frame_done,
  output logic [23:0]      frame_bytes
);

  localparam int unsigned BI_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int unsigned CNT_W = 24;
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(BYTES_PER_PIX - 1);

  localparam logic [1:0] ST_WAIT_VS = 2'd0;
  localparam logic [1:0] ST_VSYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             vs1_q, hr1_q, vs2_q, hr2_q;
  logic [7:0]       pd1_q;
  logic [COL_W-1:0] col_q, col_d, xs_q, xs_d, xl_q, xl_d;
  logic [ROW_W-1:0] row_q, row_d, ys_q, ys_d, yl_q, yl_d;
  logic [BI_W-1:0]  bidx_q, bidx_d;
  logic [1:0]       dec_q, dec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, frame_bytes_q, frame_bytes_d;
  logic             vsync_out_q, vsync_out_d, href_out_q, href_out_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       p_data_out_q, p_data_out_d;

  logic             vs_rise, vs_fall, hr_fall;
  logic [COL_W:0]   x_end;
  logic [ROW_W:0]   y_end;
  logic [COL_W-1:0] x_off, x_mask;
  logic [ROW_W-1:0] y_off, y_mask;
  logic             x_in, y_in, dec_ok, pix_ok;

  assign vs_rise = vs1_q & ~vs2_q;
  assign vs_fall = ~vs1_q & vs2_q;
  assign hr_fall = ~hr1_q & hr2_q;

  // Window and decimation qualification of the current pixel (extra bit avoids wrap)
  assign x_end  = {1'b0, xs_q} + {1'b0, xl_q};
  assign y_end  = {1'b0, ys_q} + {1'b0, yl_q};
  assign x_in   = (col_q >= xs_q) && ({1'b0, col_q} < x_end);
  assign y_in   = (row_q >= ys_q) && ({1'b0, row_q} < y_end);
  assign x_off  = col_q - xs_q;
  assign y_off  = row_q - ys_q;
  assign x_mask = ~({COL_W{1'b1}} << dec_q);
  assign y_mask = ~({ROW_W{1'b1}} << dec_q);
  assign dec_ok = ((x_off & x_mask) == '0) && ((y_off & y_mask) == '0);
  assign pix_ok = x_in && y_in && dec_ok;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    bidx_d        = bidx_q;
    xs_d          = xs_q;
    xl_d          = xl_q;
    ys_d          = ys_q;
    yl_d          = yl_q;
    dec_d         = dec_q;
    cnt_d         = cnt_q;
    frame_bytes_d = frame_bytes_q;
    frame_done_d  = 1'b0;
    href_out_d    = 1'b0;
    p_data_out_d  = pd1_q;
    vsync_out_d   = (state_q != ST_WAIT_VS) && vs1_q;
    if (!enable) begin
      state_d = ST_WAIT_VS;
    end else begin
      case (state_q)
        ST_WAIT_VS: begin
          if (vs_rise) state_d = ST_VSYNC;
        end
        ST_VSYNC: begin
          xs_d   = x_start;
          xl_d   = x_len;
          ys_d   = y_start;
          yl_d   = y_len;
          dec_d  = decim_log2;
          row_d  = '0;
          col_d  = '0;
          bidx_d = '0;
          cnt_d  = '0;
          if (vs_fall) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          // vsync wins over a coincident href byte
          if (vs_rise) begin
            frame_done_d = (cnt_q != '0);
            if (cnt_q != '0) frame_bytes_d = cnt_q;
            state_d = ST_VSYNC;
          end else if (hr_fall) begin
            col_d  = '0;
            bidx_d = '0;
            if (row_q != '1) row_d = row_q + ROW_W'(1);
          end else if (hr1_q) begin
            href_out_d = pix_ok;
            if (pix_ok && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
            if (bidx_q == BI_LAST) begin
              bidx_d = '0;
              if (col_q != '1) col_d = col_q + COL_W'(1);
            end else begin
              bidx_d = bidx_q + BI_W'(1);
            end
          end
        end
        default: state_d = ST_WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge p_clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_WAIT_VS;
      vs1_q         <= 1'b0;
      hr1_q         <= 1'b0;
      pd1_q         <= '0;
      vs2_q         <= 1'b0;
      hr2_q         <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      bidx_q        <= '0;
      xs_q          <= '0;
      xl_q          <= '0;
      ys_q          <= '0;
      yl_q          <= '0;
      dec_q         <= '0;
      cnt_q         <= '0;
      frame_bytes_q <= '0;
      frame_done_q  <= 1'b0;
      href_out_q    <= 1'b0;
      vsync_out_q   <= 1'b0;
      p_data_out_q  <= '0;
    end else begin
      state_q       <= state_d;
      vs1_q         <= vsync_in;
      hr1_q         <= href_in;
      pd1_q         <= p_data_in;
      vs2_q         <= vs1_q;
      hr2_q         <= hr1_q;
      col_q         <= col_d;
      row_q         <= row_d;
      bidx_q        <= bidx_d;
      xs_q          <= xs_d;
      xl_q          <= xl_d;
      ys_q          <= ys_d;
      yl_q          <= yl_d;
      dec_q         <= dec_d;
      cnt_q         <= cnt_d;
      frame_bytes_q <= frame_bytes_d;
      frame_done_q  <= frame_done_d;
      href_out_q    <= href_out_d;
      vsync_out_q   <= vsync_out_d;
      p_data_out_q  <= p_data_out_d;
    end
  end

  assign vsync_out   = vsync_out_q;
  assign href_out    = href_out_q;
  assign p_data_out  = p_data_out_q;
  assign frame_done  = frame_done_q;
  assign frame_bytes = frame_bytes_q;

endmodule

// File: tb/tb_cam_window_decimator.sv
// Directed bench for cam_window_decimator: drives synthetic sensor frames and
// checks emitted bytes, latency, frame_done and frame_bytes.
module tb_cam_window_decimator;

  logic        p_clock;
  logic        resetn;
  logic        enable;
  logic [10:0] x_start, x_len;
  logic [9:0]  y_start, y_len;
  logic [1:0]  decim_log2;
  logic        vsync_in, href_in;
  logic [7:0]  p_data_in;
  logic        vsync_out, href_out, frame_done;
  logic [7:0]  p_data_out;
  logic [23:0] frame_bytes;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  logic [7:0] got[$];
  int         got_cyc[$];
  int         in_cyc[$];
  logic [7:0] exp_q[$];
  int         rst_cyc;

  cam_window_decimator #(.BYTES_PER_PIX(2), .COL_W(11), .ROW_W(10)) dut (
    .p_clock(p_clock), .resetn(resetn), .enable(enable),
    .x_start(x_start), .x_len(x_len), .y_start(y_start), .y_len(y_len),
    .decim_log2(decim_log2), .vsync_in(vsync_in), .href_in(href_in),
    .p_data_in(p_data_in), .vsync_out(vsync_out), .href_out(href_out),
    .p_data_out(p_data_out), .frame_done(frame_done), .frame_bytes(frame_bytes)
  );

  initial p_clock = 1'b0;
  always #5 p_clock = ~p_clock;
  always @(posedge p_clock) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle
  always @(negedge p_clock) begin
    if (href_out) begin
      got.push_back(p_data_out);
      got_cyc.push_back(cyc);
    end
    if (frame_done) done_cnt++;
  end

  function automatic logic [7:0] pix(input int r, input int c, input int b);
    logic [2:0] rr;
    logic [3:0] cc;
    logic       bb;
    rr = 3'(r);
    cc = 4'(c);
    bb = 1'(b);
    return {rr, cc, bb};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
  endtask

  task automatic set_cfg(input int xs, input int xl, input int ys, input int yl, input int d);
    x_start = 11'(xs); x_len = 11'(xl);
    y_start = 10'(ys); y_len = 10'(yl);
    decim_log2 = 2'(d);
  endtask

  task automatic build_exp(input int nc, input int nr, input int xs, input int xl,
                           input int ys, input int yl, input int d);
    exp_q.delete();
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        if (c >= xs && c < xs + xl && r >= ys && r < ys + yl &&
            ((c - xs) % (1 << d)) == 0 && ((r - ys) % (1 << d)) == 0)
          for (int b = 0; b < 2; b++) exp_q.push_back(pix(r, c, b));
  endtask

  task automatic chk_content(input string tag);
    int ok;
    ok = (got.size() == exp_q.size()) ? 1 : 0;
    if (ok == 1)
      for (int i = 0; i < got.size(); i++)
        if (got[i] !== exp_q[i]) ok = 0;
    chk(tag, ok, 1);
  endtask

  task automatic vs_pulse();
    repeat (3) begin @(negedge p_clock); vsync_in = 1'b1; href_in = 1'b0; end
    repeat (4) begin @(negedge p_clock); vsync_in = 1'b0; end
  endtask

  // One sensor line; rst_at >= 0 pulses resetn low at that byte index
  task automatic drive_row(input int r, input int nc, input int rst_at);
    int k;
    k = 0;
    for (int c = 0; c < nc; c++)
      for (int b = 0; b < 2; b++) begin
        @(negedge p_clock);
        if (k == rst_at) begin resetn = 1'b0; rst_cyc = cyc; end
        if (k == rst_at + 2 && rst_at >= 0) resetn = 1'b1;
        href_in = 1'b1;
        p_data_in = pix(r, c, b);
        in_cyc.push_back(cyc);
        k++;
      end
    repeat (4) begin @(negedge p_clock); href_in = 1'b0; p_data_in = 8'h00; end
  endtask

  task automatic drive_frame(input int nc, input int nr);
    for (int r = 0; r < nr; r++) drive_row(r, nc, -1);
  endtask

  task automatic clear_obs();
    got.delete(); got_cyc.delete(); in_cyc.delete(); done_cnt = 0;
  endtask

  initial begin
    int late;
    resetn = 1'b0; enable = 1'b1;
    vsync_in = 1'b0; href_in = 1'b0; p_data_in = 8'h00;
    set_cfg(0, 8, 0, 4, 0);
    repeat (3) @(negedge p_clock);
    resetn = 1'b1;
    @(negedge p_clock);
    chk("rst_vsync_out", int'(vsync_out), 0);
    chk("rst_href_out", int'(href_out), 0);
    chk("rst_p_data_out", int'(p_data_out), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_bytes", int'(frame_bytes), 0);

    // 1: full window 8x4, pass-through
    vs_pulse();
    clear_obs();
    drive_frame(8, 4);
    set_cfg(2, 4, 1, 2, 0);
    vs_pulse();
    build_exp(8, 4, 0, 8, 0, 4, 0);
    chk("t1_count", got.size(), 64);
    chk_content("t1_content");
    chk("t1_latency", (got_cyc.size() > 0 && in_cyc.size() > 0) ? got_cyc[0] - in_cyc[0] : -1, 2);
    chk("t1_done", done_cnt, 1);
    chk("t1_frame_bytes", int'(frame_bytes), 64);

    // 2: cropped window
    clear_obs();
    drive_frame(8, 4);
    set_cfg(0, 0, 0, 4, 0);
    vs_pulse();
    build_exp(8, 4, 2, 4, 1, 2, 0);
    chk("t2_count", got.size(), 16);
    chk_content("t2_content");
    chk("t2_done", done_cnt, 1);
    chk("t2_frame_bytes", int'(frame_bytes), 16);

    // 4: empty window keeps previous frame_bytes
    clear_obs();
    drive_frame(8, 4);
    set_cfg(0, 16, 0, 8, 1);
    vs_pulse();
    chk("t4_count", got.size(), 0);
    chk("t4_done", done_cnt, 0);
    chk("t4_frame_bytes", int'(frame_bytes), 16);

    // 3: 16x8 decimated by 2
    clear_obs();
    drive_frame(16, 8);
    set_cfg(0, 8, 0, 4, 0);
    vs_pulse();
    build_exp(16, 8, 0, 16, 0, 8, 1);
    chk("t3_count", got.size(), 64);
    chk_content("t3_content");
    chk("t3_done", done_cnt, 1);
    chk("t3_frame_bytes", int'(frame_bytes), 64);

    // 5: reset in mid-row 2, remainder of frame suppressed
    clear_obs();
    drive_row(0, 8, -1);
    drive_row(1, 8, -1);
    drive_row(2, 8, 5);
    drive_row(3, 8, -1);
    late = 0;
    foreach (got_cyc[i]) if (got_cyc[i] > rst_cyc) late++;
    chk("t5_after_reset_bytes", late, 0);
    chk("t5_frame_bytes_cleared", int'(frame_bytes), 0);
    vs_pulse();
    chk("t5_no_done_partial", done_cnt, 0);
    clear_obs();
    drive_frame(8, 4);
    vs_pulse();
    chk("t5_count", got.size(), 64);
    chk("t5_done", done_cnt, 1);
    chk("t5_frame_bytes", int'(frame_bytes), 64);

    // 6: mid-frame x_start change applies to the next frame only
    clear_obs();
    drive_row(0, 8, -1);
    drive_row(1, 8, -1);
    set_cfg(4, 8, 0, 4, 0);
    drive_row(2, 8, -1);
    drive_row(3, 8, -1);
    vs_pulse();
    build_exp(8, 4, 0, 8, 0, 4, 0);
    chk("t6a_count", got.size(), 64);
    chk_content("t6a_content");
    chk("t6a_frame_bytes", int'(frame_bytes), 64);
    clear_obs();
    drive_frame(8, 4);
    vs_pulse();
    build_exp(8, 4, 4, 8, 0, 4, 0);
    chk("t6b_count", got.size(), 32);
    chk_content("t6b_content");
    chk("t6b_frame_bytes", int'(frame_bytes), 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
